// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave receiver.
// Build option SPI_SLAVE_SYNC_EN: when defined, each serial input passes
// through a 2-flop synchronizer ahead of its capture register (asynchronous
// master); when undefined, a single capture register (same-clock master).
package spi_pkg;

  localparam int   SPI_DATALENGTH = 8;

  // Idle levels of the serial lines; the input chains reset to these.
  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;

`ifdef SPI_SLAVE_SYNC_EN
  localparam int SYNC_DEPTH = 3;
`else
  localparam int SYNC_DEPTH = 1;
`endif

endpackage

// File: rtl/spi_input_sync.sv
// Per-bit input register chain for one serial line. Depth is 1 by default,
// 3 (2-flop synchronizer plus capture register) with SPI_SLAVE_SYNC_EN.
// All three serial lines use the same depth so they stay mutually aligned.
module spi_input_sync
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DEPTH-1:0] chain_q;

  // Shift the pin level through the chain; the oldest stage is the output.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, exactly as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {SYNC_DEPTH{RESET_VAL}};
    else        chain_q <= SYNC_DEPTH'({chain_q, d_i});
  end

  assign q_o = chain_q[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_slave_receiver.sv
// CPOL=0 SPI slave: oversamples SCLK/CS/MOSI in the clk domain, deserialises
// MOSI MSB-first into recvData with a one-cycle recvValid strobe, and shifts a
// staged reply word out on MISO. Honours SPI_SLAVE_SYNC_EN (see spi_pkg).
module spi_slave_receiver
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATALENGTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txLoad,
  output logic                  txPending,
  output logic [DATA_WIDTH-1:0] recvData,
  output logic                  recvValid,
  output logic                  frameError,
  output logic                  busy
);

  localparam int               CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [1:0]       FILL_DONE = 2'(SYNC_DEPTH);

  logic sclk_q, cs_q, mosi_q;
  logic sclk_d;
  logic cs_prev_q;
  logic [1:0] fill_q;
  logic armed_q;

  logic [DATA_WIDTH-1:0] tx_hold_q, tx_shift_q, rx_shift_q, recv_data_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  tx_pending_q, recv_valid_q, frame_error_q;

  logic idle, rise, last_bit, frame_start, frame_end, word_done, consume;

  spi_input_sync #(.RESET_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst_n(rst), .d_i(SCLK), .q_o(sclk_q));
  spi_input_sync #(.RESET_VAL(CS_IDLE)) u_sync_cs (
    .clk(clk), .rst_n(rst), .d_i(CS), .q_o(cs_q));
  spi_input_sync #(.RESET_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk(clk), .rst_n(rst), .d_i(MOSI), .q_o(mosi_q));

  // A frame only counts once CS has been seen high after reset (armed_q), so a
  // reset in the middle of a frame does not pick that frame up half-way.
  assign idle        = cs_q | ~armed_q;
  assign rise        = sclk_q & ~sclk_d & ~idle;
  assign last_bit    = (bit_cnt_q == LAST_BIT);
  assign frame_start = ~idle & cs_prev_q;
  assign frame_end   = idle & ~cs_prev_q;
  assign word_done   = rise & last_bit;
  assign consume     = frame_start | word_done;

  // Edge history for SCLK/CS and the post-reset arming of frame detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_d    <= SCLK_IDLE;
      cs_prev_q <= CS_IDLE;
      fill_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      sclk_d    <= sclk_q;
      cs_prev_q <= idle;
      if (fill_q != FILL_DONE) fill_q <= fill_q + 2'd1;
      // Only trust cs_q once the chain holds real pin samples, not reset values.
      if (fill_q == FILL_DONE && cs_q == CS_IDLE) armed_q <= 1'b1;
    end
  end

  // Reply hold register: a load always wins over a simultaneous consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_hold_q    <= '0;
      tx_pending_q <= 1'b0;
    end else if (txLoad) begin
      tx_hold_q    <= txData;
      tx_pending_q <= 1'b1;
    end else if (consume) begin
      tx_pending_q <= 1'b0;
    end
  end

  // Shift registers and bit counter; idle keeps the reply shifter primed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
    end else if (idle) begin
      tx_shift_q <= tx_hold_q;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
    end else if (rise) begin
      rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_q};
      if (last_bit) begin
        // Reload at the word boundary so back-to-back words need no CS toggle.
        tx_shift_q <= tx_hold_q;
        bit_cnt_q  <= '0;
      end else begin
        tx_shift_q <= tx_shift_q << 1;
        bit_cnt_q  <= bit_cnt_q + 1'b1;
      end
    end
  end

  // Registered status outputs: word strobe, received word and abort strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      recv_data_q   <= '0;
      recv_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      recv_valid_q  <= word_done;
      frame_error_q <= frame_end & (bit_cnt_q != '0);
      if (word_done) recv_data_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_q};
    end
  end

  // MISO changes only when tx_shift_q does, i.e. 1 clk after a detected rise,
  // so the bit is still stable at the master's falling-edge sample.
  assign MISO       = ~idle & tx_shift_q[DATA_WIDTH-1];
  assign busy       = ~idle;
  assign txPending  = tx_pending_q;
  assign recvData   = recv_data_q;
  assign recvValid  = recv_valid_q;
  assign frameError = frame_error_q;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Self-checking bench for spi_slave_receiver: a bench-side SPI master drives
// frames, a reference model tracks the reply hold word, and a monitor checks
// every recvValid pulse against a queue of expected received words.
module tb_spi_slave_receiver;

`ifdef SPI_SLAVE_SYNC_EN
  localparam int DEPTH = 3;
  localparam int HI    = 3;
  localparam int LO    = 3;
`else
  localparam int DEPTH = 1;
  localparam int HI    = 1;
  localparam int LO    = 2;
`endif

  logic       clk = 1'b0;
  logic       rst, SCLK, CS, MOSI, txLoad;
  logic [7:0] txData;
  logic       MISO, txPending, recvValid, frameError, busy;
  logic [7:0] recvData;

  spi_slave_receiver #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .txData(txData), .txLoad(txLoad), .txPending(txPending),
    .recvData(recvData), .recvValid(recvValid), .frameError(frameError),
    .busy(busy));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard and reference model state.
  logic [7:0] rx_q[$];
  int         fe_exp  = 0;
  int         fe_seen = 0;
  logic [7:0] m_hold  = 8'h00;
  logic [7:0] m_tx    = 8'h00;
  logic [7:0] m_recv  = 8'h00;
  logic       m_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every recvValid cycle must match the next expected word.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (recvValid === 1'b1) begin
        if (rx_q.size() == 0) check("recvValid_unexpected", 32'(recvValid), 32'd0);
        else                  check("recvData", 32'(recvData), 32'(rx_q.pop_front()));
      end
      if (frameError === 1'b1) fe_seen++;
    end
  end

  task automatic load(input logic [7:0] d);
    txData = d;
    txLoad = 1'b1;
    tick(1);
    txLoad = 1'b0;
    m_hold = d;
    m_pending = 1'b1;
  endtask

  // CS falls; the word shifted out first is whatever the hold register had.
  // With with_load, txLoad is pulsed in the first cycle CS is seen low.
  task automatic frame_begin(input bit with_load, input logic [7:0] d);
    CS = 1'b0;
    m_tx = m_hold;
    m_pending = 1'b0;
    if (with_load) begin
      tick(DEPTH);
      txData = d;
      txLoad = 1'b1;
      tick(1);
      txLoad = 1'b0;
      m_hold = d;
      m_pending = 1'b1;
      tick(2);
    end else begin
      tick(DEPTH + 2);
    end
  endtask

  task automatic frame_end();
    CS = 1'b1;
    tick(DEPTH + 3);
    check("frameError_count", 32'(fe_seen), 32'(fe_exp));
    check("txPending_idle", 32'(txPending), 32'(m_pending));
    check("recvData_held", 32'(recvData), 32'(m_recv));
  endtask

  // Master side of one bit: drive MOSI with the SCLK rise, sample MISO at the fall.
  task automatic send_bits(input logic [7:0] d, input int n, input bit mid_load,
                           input logic [7:0] ld, output logic [7:0] miso_w);
    miso_w = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = d[7-i];
      SCLK = 1'b1;
      tick(HI);
      miso_w = {miso_w[6:0], MISO};
      SCLK = 1'b0;
      tick(LO);
      if (mid_load && i == 3) load(ld);
    end
  endtask

  task automatic send_word(input logic [7:0] d, input bit mid_load, input logic [7:0] ld);
    logic [7:0] got;
    rx_q.push_back(d);
    send_bits(d, 8, mid_load, ld, got);
    check("miso_word", 32'(got), 32'(m_tx));
    m_recv = d;
    m_tx = m_hold;
    m_pending = 1'b0;
  endtask

  task automatic abort_word(input logic [7:0] d, input int n);
    logic [7:0] got;
    send_bits(d, n, 1'b0, 8'h00, got);
    fe_exp++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_recvData"},   32'(recvData),   32'd0);
    check({tag, "_recvValid"},  32'(recvValid),  32'd0);
    check({tag, "_frameError"}, 32'(frameError), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_MISO"},       32'(MISO),       32'd0);
    check({tag, "_txPending"},  32'(txPending),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] scratch;
    rst = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0; txLoad = 1'b0; txData = 8'h00;
    tick(1);
    rst = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick(DEPTH + 4);

    // Single word: reply 0x3C, receive 0xA5.
    load(8'h3C);
    check("txPending_loaded", 32'(txPending), 32'd1);
    frame_begin(1'b0, 8'h00);
    check("txPending_cs_fall", 32'(txPending), 32'd0);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_word(8'hA5, 1'b0, 8'h00);
    frame_end();

    // Back-to-back words under one CS; the second reply is loaded mid-word.
    load(8'h11);
    frame_begin(1'b0, 8'h00);
    send_word(8'h01, 1'b1, 8'h22);
    send_word(8'h02, 1'b0, 8'h00);
    frame_end();

    // Abort after 3 bits, then a clean frame.
    frame_begin(1'b0, 8'h00);
    abort_word(8'hFF, 3);
    frame_end();
    frame_begin(1'b0, 8'h00);
    send_word(8'h5A, 1'b0, 8'h00);
    frame_end();

    // Overwrite before the frame: last load wins.
    load(8'hAA);
    load(8'hBB);
    frame_begin(1'b0, 8'h00);
    send_word(8'h3E, 1'b0, 8'h00);
    frame_end();

    // Load coinciding with the frame-start consume.
    load(8'h66);
    frame_begin(1'b1, 8'h77);
    check("txPending_load_at_start", 32'(txPending), 32'd1);
    send_word(8'h81, 1'b0, 8'h00);
    frame_end();

    // Reset during bit 4; CS stays low through release and must be ignored.
    load(8'h99);
    frame_begin(1'b0, 8'h00);
    send_bits(8'hF0, 3, 1'b0, 8'h00, scratch);
    MOSI = 1'b1;
    SCLK = 1'b1;
    tick(1);
    rst = 1'b0;
    SCLK = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    rx_q.delete();
    m_hold = 8'h00; m_tx = 8'h00; m_recv = 8'h00; m_pending = 1'b0;
    rst = 1'b1;
    tick(DEPTH + 4);
    check("busy_cs_held_low", 32'(busy), 32'd0);
    CS = 1'b1;
    tick(DEPTH + 3);
    frame_begin(1'b0, 8'h00);
    send_word(8'hC3, 1'b0, 8'h00);
    frame_end();

    // Randomized frames against the model.
    for (int f = 0; f < 24; f++) begin
      int nw;
      if ($urandom_range(0, 1) == 1) load(8'($urandom));
      frame_begin(($urandom_range(0, 3) == 0), 8'($urandom));
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        send_word(8'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom));
        if ($urandom_range(0, 3) == 0) load(8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) abort_word(8'($urandom), $urandom_range(1, 7));
      frame_end();
    end

    tick(4);
    check("recv_words_outstanding", 32'(rx_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
